// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - pattern/key/display bundle for stage_sequencer
// retry_used exists only when STAGE_SEQUENCER_RETRY_EN is defined.
interface stage_sequencer_if #(
  parameter int STAGES = 5,
  parameter int DATA_W = 2
);
  logic                     start;
  logic [STAGES*DATA_W-1:0] pattern;
  logic                     key_valid;
  logic [DATA_W-1:0]        key_data;
  logic [DATA_W-1:0]        current_data;
  logic [3:0]               stage_idx;
  logic                     show;
  logic                     busy;
  logic                     pass;
  logic                     fail;
  logic [3:0]               score;
`ifdef STAGE_SEQUENCER_RETRY_EN
  logic                     retry_used;
`endif

  modport master (
    output start, pattern, key_valid, key_data,
    input  current_data, stage_idx, show, busy, pass, fail, score
`ifdef STAGE_SEQUENCER_RETRY_EN
    , input retry_used
`endif
  );

  modport slave (
    input  start, pattern, key_valid, key_data,
    output current_data, stage_idx, show, busy, pass, fail, score
`ifdef STAGE_SEQUENCER_RETRY_EN
    , output retry_used
`endif
  );
endinterface

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - single-clock show/wait/compare sequencer over a latched symbol pattern
// Optional STAGE_SEQUENCER_RETRY_EN grants one retry per round on mismatch or timeout.
module stage_sequencer #(
  parameter int STAGES      = 5,
  parameter int DATA_W      = 2,
  parameter int SHOW_CYCLES = 4,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  stage_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SHOW, WAIT, PASS, FAIL} state_t;

  localparam int               PAT_W     = 16 * DATA_W;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LAST_IDX  = 4'(STAGES - 1);
  localparam logic [3:0]       SCORE_MAX = 4'(STAGES);

  state_t            state;
  logic [CNT_W-1:0]  cnt_q;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  pat_in;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        stage_q;
  logic [3:0]        score_q;
  logic              show_q;
  logic              busy_q;
  logic              pass_q;
  logic              fail_q;
  logic              retry_q;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] next_entry;
  logic              hit;
  logic              miss;

  // Zero-extended to 16 entries so any 4-bit stage index stays inside the vector.
  assign pat_in = PAT_W'(bus.pattern);

  always_comb begin
    expected   = pat_q[int'(stage_q) * DATA_W +: DATA_W];
    next_entry = pat_q[(int'(stage_q) + 1) * DATA_W +: DATA_W];
    hit        = bus.key_valid && (bus.key_data == expected);
    miss       = bus.key_valid ? (bus.key_data != expected) : (cnt_q == TO_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      data_q  <= '0;
      stage_q <= '0;
      score_q <= '0;
      show_q  <= 1'b0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      retry_q <= 1'b0;
    end else begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            pat_q   <= pat_in;
            data_q  <= pat_in[DATA_W-1:0];
            stage_q <= '0;
            score_q <= '0;
            cnt_q   <= '0;
            show_q  <= 1'b1;
            busy_q  <= 1'b1;
            retry_q <= 1'b0;
            state   <= SHOW;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_q  <= '0;
            show_q <= 1'b0;
            state  <= WAIT;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (hit) begin
            if (score_q != SCORE_MAX) score_q <= score_q + 4'd1;
            if (stage_q == LAST_IDX) begin
              pass_q <= 1'b1;
              state  <= PASS;
            end else begin
              stage_q <= stage_q + 4'd1;
              data_q  <= next_entry;
              cnt_q   <= '0;
              show_q  <= 1'b1;
              state   <= SHOW;
            end
          end else if (miss) begin
`ifdef STAGE_SEQUENCER_RETRY_EN
            if (!retry_q) begin
              // Replay the same stage once; current_data already holds its symbol.
              retry_q <= 1'b1;
              cnt_q   <= '0;
              show_q  <= 1'b1;
              state   <= SHOW;
            end else begin
              fail_q <= 1'b1;
              state  <= FAIL;
            end
`else
            fail_q <= 1'b1;
            state  <= FAIL;
`endif
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PASS, FAIL: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.current_data = data_q;
  assign bus.stage_idx    = stage_q;
  assign bus.show         = show_q;
  assign bus.busy         = busy_q;
  assign bus.pass         = pass_q;
  assign bus.fail         = fail_q;
  assign bus.score        = score_q;
`ifdef STAGE_SEQUENCER_RETRY_EN
  assign bus.retry_used   = retry_q;
`else
  logic unused_retry;
  assign unused_retry = retry_q;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed self-checking bench for stage_sequencer
// Honours STAGE_SEQUENCER_RETRY_EN when defined.
module tb_stage_sequencer;
  localparam int STAGES = 5;
  localparam int DATA_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage_sequencer_if #(.STAGES(STAGES), .DATA_W(DATA_W)) bus ();

  stage_sequencer #(
    .STAGES(STAGES), .DATA_W(DATA_W), .SHOW_CYCLES(4), .TIMEOUT(255), .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] e1 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [9:0] p1 = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
  logic [9:0] p2 = {2'd3, 2'd3, 2'd1, 2'd0, 2'd2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [9:0] p);
    bus.pattern = p;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic press(input logic [1:0] d);
    bus.key_valid = 1'b1;
    bus.key_data = d;
    step();
    bus.key_valid = 1'b0;
  endtask

  // Expects to be called in the first SHOW cycle; returns in the first WAIT cycle.
  task automatic run_show(input int s, input logic [1:0] d, input bit poke);
    for (int i = 0; i < 4; i++) begin
      check("show_hi", bus.show, 1);
      check("show_data", bus.current_data, d);
      check("show_stage", bus.stage_idx, s);
      if (poke && i == 1) begin
        bus.key_valid = 1'b1;
        bus.key_data = ~d;
        bus.start = 1'b1;
      end
      step();
      bus.key_valid = 1'b0;
      bus.start = 1'b0;
    end
    check("show_lo", bus.show, 0);
    check("wait_stage", bus.stage_idx, s);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.pattern = '0;
    bus.key_valid = 1'b0;
    bus.key_data = '0;
    #1;
    check("rst_data", bus.current_data, 0);
    check("rst_stage", bus.stage_idx, 0);
    check("rst_show", bus.show, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_score", bus.score, 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    check("idle_busy", bus.busy, 0);

    // Full pass, with ignored key/start in SHOW and start in WAIT
    do_start(p1);
    check("start_busy", bus.busy, 1);
    for (int s = 0; s < 5; s++) begin
      run_show(s, e1[s], s == 0);
      check("score_pre_key", bus.score, s);
      if (s == 2) begin
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("wstart_stage", bus.stage_idx, 2);
        check("wstart_show", bus.show, 0);
        check("wstart_busy", bus.busy, 1);
        check("wstart_score", bus.score, 2);
      end
      press(e1[s]);
      if (s < 4) check("adv_score", bus.score, s + 1);
    end
    check("pass_pulse", bus.pass, 1);
    check("pass_score", bus.score, 5);
    check("pass_stage", bus.stage_idx, 4);
    check("pass_busy", bus.busy, 1);
    step();
    check("pass_drop", bus.pass, 0);
    check("pass_idle_busy", bus.busy, 0);
    check("pass_hold_score", bus.score, 5);

    // Mismatch at stage 2
    do_start(p1);
    check("restart_score", bus.score, 0);
    run_show(0, 2'd0, 1'b0);
    press(2'd0);
    run_show(1, 2'd1, 1'b0);
    press(2'd1);
    run_show(2, 2'd2, 1'b0);
    press(2'd1);
`ifdef STAGE_SEQUENCER_RETRY_EN
    check("retry_nofail", bus.fail, 0);
    check("retry_flag", bus.retry_used, 1);
    check("retry_score", bus.score, 2);
    run_show(2, 2'd2, 1'b0);
    press(2'd1);
`endif
    check("miss_fail", bus.fail, 1);
    check("miss_score", bus.score, 2);
    check("miss_stage", bus.stage_idx, 2);
    step();
    check("miss_fail_drop", bus.fail, 0);
    check("miss_idle_busy", bus.busy, 0);
    check("miss_hold_stage", bus.stage_idx, 2);

    // Timeout in stage 0
    do_start(p1);
`ifdef STAGE_SEQUENCER_RETRY_EN
    check("retry_clr", bus.retry_used, 0);
`endif
    run_show(0, 2'd0, 1'b0);
    repeat (255) step();
    check("to_not_yet", bus.fail, 0);
    check("to_busy", bus.busy, 1);
    step();
`ifdef STAGE_SEQUENCER_RETRY_EN
    check("to_retry_nofail", bus.fail, 0);
    check("to_retry_flag", bus.retry_used, 1);
    run_show(0, 2'd0, 1'b0);
    repeat (256) step();
`endif
    check("to_fail", bus.fail, 1);
    check("to_score", bus.score, 0);
    step();
    check("to_fail_drop", bus.fail, 0);

    // Key on the timeout boundary wins, then reset mid-round in stage 3 WAIT
    do_start(p1);
    run_show(0, 2'd0, 1'b0);
    repeat (255) step();
    press(2'd0);
    check("edge_nofail", bus.fail, 0);
    check("edge_score", bus.score, 1);
    check("edge_stage", bus.stage_idx, 1);
    run_show(1, 2'd1, 1'b0);
    press(2'd1);
    run_show(2, 2'd2, 1'b0);
    press(2'd2);
    run_show(3, 2'd3, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("mrst_data", bus.current_data, 0);
    check("mrst_stage", bus.stage_idx, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_score", bus.score, 0);
    check("mrst_show", bus.show, 0);
`ifdef STAGE_SEQUENCER_RETRY_EN
    check("mrst_retry", bus.retry_used, 0);
`endif
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_show", bus.show, 0);

    // New pattern re-latched on start
    do_start(p2);
    run_show(0, 2'd2, 1'b0);
    press(2'd0);
`ifdef STAGE_SEQUENCER_RETRY_EN
    check("p2_retry", bus.retry_used, 1);
    check("p2_show", bus.show, 1);
`else
    check("p2_fail", bus.fail, 1);
`endif
    check("p2_score", bus.score, 0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Clocked controller that steps a player through a fixed-length sequence of 2-bit symbols.
- At each stage it shows the expected symbol, waits for a keyed response, compares the two, and either advances, passes or fails.
- Replaces ad-hoc edge-driven stage stepping with a single-clock FSM.
- Sits between the pattern source (switches/ROM) and the display/score logic.

Parameters:
- STAGES, 5, number of sequence entries per round (2..15).
- DATA_W, 2, symbol width in bits.
- SHOW_CYCLES, 4, cycles each symbol is presented (>=1).
- TIMEOUT, 255, cycles allowed for a response before fail (>=1, fits in CNT_W).
- CNT_W, 8, width of the show/timeout counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a round; ignored unless in IDLE.
- pattern  in  STAGES*DATA_W  sequence; entry k = pattern[k*DATA_W +: DATA_W]; sampled only on accepted start.
- key_valid  in  1  one-cycle strobe: player response present.
- key_data  in  DATA_W  player response, qualified by key_valid.
- current_data  out  DATA_W  symbol of the current stage.
- stage_idx  out  4  current stage index, 0..STAGES-1.
- show  out  1  high while current_data is being presented.
- busy  out  1  high in every state except IDLE.
- pass  out  1  one-cycle pulse: all stages matched.
- fail  out  1  one-cycle pulse: mismatch or timeout.
- score  out  4  stages matched in the last/current round.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE. current_data=0, stage_idx=0, show=0, busy=0, pass=0, fail=0, score=0, counter=0, latched pattern=0.
- States: IDLE, SHOW, WAIT, PASS, FAIL.
- IDLE:
  - start=1: latch pattern, stage_idx=0, score=0, counter=0; go to SHOW next cycle.
  - score holds its value from the previous round until the next accepted start.
- SHOW:
  - show=1 and current_data=latched entry[stage_idx]; the output is registered and valid in the first SHOW cycle.
  - Counter increments each cycle; after exactly SHOW_CYCLES cycles go to WAIT with counter cleared.
  - key_valid is ignored in SHOW.
- WAIT:
  - show=0; current_data holds its value.
  - Counter increments each cycle without key_valid.
  - key_valid with key_data==entry[stage_idx]: score+1.
    - If stage_idx==STAGES-1, go to PASS.
    - Else stage_idx+1 and go to SHOW, counter cleared.
  - key_valid with a mismatch: go to FAIL.
  - If counter reaches TIMEOUT without key_valid: go to FAIL.
  - key_valid on the same cycle the counter reaches TIMEOUT: the key wins and is evaluated.
- PASS / FAIL:
  - Assert pass or fail for exactly one cycle, then return to IDLE.
  - stage_idx holds the failing or last stage until the next start.
- start outside IDLE: no effect; it is not queued.
- Response latency: key_valid in WAIT at cycle n gives the state change and score update at n+1, and the pass/fail pulse at n+1.
- Counters saturate and never wrap. score never exceeds STAGES.
- reset deassertion mid-round is a clean restart from IDLE; no partial round state survives.

Optional Feature:
- Macro: STAGE_SEQUENCER_RETRY_EN.
- Defined:
  - The first mismatch or timeout in a round does not fail. The block re-enters SHOW for the same stage_idx and sets internal retry_used.
  - Port retry_used (out, 1) is exposed. It is cleared on accepted start and on reset.
  - A second mismatch or timeout in the same round goes to FAIL.
  - score is unaffected by the retry itself.
- Undefined:
  - Any mismatch or timeout goes straight to FAIL.
  - No retry_used port exists.

Test Plan:
- Full pass: pattern entries {0,1,2,3,0}, start, answer each entry correctly in WAIT → pass pulses once, score=5, stage_idx=4, busy drops the cycle after pass.
- Mismatch: same pattern, stage 2 expects 2, key 1 → fail pulse, score=2, stage_idx=2; with RETRY_EN → back to SHOW for stage 2, retry_used=1, no fail.
- Timeout: no key_valid for TIMEOUT cycles in stage 0 → fail exactly TIMEOUT+1 cycles after WAIT entry, score=0; key_valid on the boundary cycle is evaluated instead.
- Ignored inputs: key_valid during SHOW and start during WAIT → no state change, score unchanged, round continues.
- Reset mid-round: assert reset=0 in stage 3 WAIT → all outputs 0 immediately (asynchronous); after release, start needed to begin a new round; pattern re-latched.
- Show timing: SHOW_CYCLES=4 → show high exactly 4 cycles per stage, current_data equals entry[stage_idx] from the first show cycle.
